mem_arbiter: RTL and testbench

//  Shares the single unified instruction/data memory between two requesters: the multicycle core
//  (fetch/load/store issued by the control-unit sequence) and the program loader port.

---
 rtl/mem_arbiter_pkg.sv | 13 +
 rtl/arb_wait_counter.sv | 29 ++
 rtl/mem_arbiter.sv | 126 ++++++++++++
 tb/tb_mem_arbiter.sv | 244 ++++++++++++++++++++++++
 4 files changed

// File: rtl/mem_arbiter_pkg.sv
// Shared definitions for the unified-memory arbiter: FSM state encodings and grant owner codes.
package mem_arbiter_pkg;

    typedef enum logic [1:0] {
        IDLE   = 2'b00,
        ACCESS = 2'b01,
        RESP   = 2'b10
    } arbState_t;

    localparam logic GRANT_CPU = 1'b0;
    localparam logic GRANT_LD  = 1'b1;

endpackage

// File: rtl/arb_wait_counter.sv
// Access-length counter: loaded at grant, decremented each ACCESS cycle, registered zero flag.
module arb_wait_counter #(
    parameter int unsigned WIDTH = 2
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             load,
    input  logic [WIDTH-1:0] loadVal,
    input  logic             dec,
    output logic             zero
);

    logic [WIDTH-1:0] cnt;

    // zero tracks the value cnt will hold next cycle, so it is valid in the same cycle as cnt
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            cnt  <= '0;
            zero <= 1'b1;
        end else if (load) begin
            cnt  <= loadVal;
            zero <= (loadVal == '0);
        end else if (dec && (cnt != '0)) begin
            cnt  <= cnt - WIDTH'(1);
            zero <= (cnt == WIDTH'(1));
        end
    end

endmodule

// File: rtl/mem_arbiter.sv
// Arbitrates the unified instruction/data memory between the core and the program loader,
// holds mem_en for MEM_LATENCY cycles and returns a one-cycle ack with registered read data.
module mem_arbiter
    import mem_arbiter_pkg::*;
#(
    parameter int unsigned ADDR_WIDTH     = 32,
    parameter int unsigned DATA_WIDTH     = 32,
    parameter int unsigned MEM_LATENCY    = 2,
    parameter int unsigned FIXED_PRIORITY = 0
) (
    input  logic                  clk,
    input  logic                  rst_n,
    input  logic                  cpu_req,
    input  logic                  cpu_we,
    input  logic [ADDR_WIDTH-1:0] cpu_addr,
    input  logic [DATA_WIDTH-1:0] cpu_wdata,
    output logic                  cpu_ack,
    output logic                  cpu_stall,
    input  logic                  ld_req,
    input  logic                  ld_we,
    input  logic [ADDR_WIDTH-1:0] ld_addr,
    input  logic [DATA_WIDTH-1:0] ld_wdata,
    output logic                  ld_ack,
    output logic [DATA_WIDTH-1:0] rdata,
    output logic                  mem_en,
    output logic                  mem_we,
    output logic [ADDR_WIDTH-1:0] mem_addr,
    output logic [DATA_WIDTH-1:0] mem_wdata,
    input  logic [DATA_WIDTH-1:0] mem_rdata,
    output logic                  busy,
    output logic                  grant
);

    localparam int unsigned CNT_W = $clog2(MEM_LATENCY + 1);

    arbState_t state;
    logic      lastGrant;
    logic      winner;
    logic      anyReq;
    logic      cntLoad;
    logic      cntDec;
    logic      cntZero;

    assign anyReq    = cpu_req | ld_req;
    assign cntLoad   = (state == IDLE) && anyReq;
    assign cntDec    = (state == ACCESS) && !cntZero;
    assign cpu_stall = cpu_req & ~cpu_ack;

    // On conflict round-robin favours whoever did not own the previous access
    always_comb begin
        winner = GRANT_CPU;
        if (cpu_req && ld_req) begin
            winner = (FIXED_PRIORITY != 0) ? GRANT_CPU : ~lastGrant;
        end else if (ld_req) begin
            winner = GRANT_LD;
        end
    end

    arb_wait_counter #(
        .WIDTH (CNT_W)
    ) u_wait_counter (
        .clk     (clk),
        .rst_n   (rst_n),
        .load    (cntLoad),
        .loadVal (CNT_W'(MEM_LATENCY - 1)),
        .dec     (cntDec),
        .zero    (cntZero)
    );

    // mem_we doubles as the latched write flag, so it can only be high alongside mem_en
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state     <= IDLE;
            lastGrant <= GRANT_LD;
            grant     <= GRANT_CPU;
            busy      <= 1'b0;
            mem_en    <= 1'b0;
            mem_we    <= 1'b0;
            mem_addr  <= '0;
            mem_wdata <= '0;
            rdata     <= '0;
            cpu_ack   <= 1'b0;
            ld_ack    <= 1'b0;
        end else begin
            cpu_ack <= 1'b0;
            ld_ack  <= 1'b0;
            case (state)
                IDLE: begin
                    if (anyReq) begin
                        grant     <= winner;
                        busy      <= 1'b1;
                        mem_en    <= 1'b1;
                        mem_we    <= (winner == GRANT_LD) ? ld_we    : cpu_we;
                        mem_addr  <= (winner == GRANT_LD) ? ld_addr  : cpu_addr;
                        mem_wdata <= (winner == GRANT_LD) ? ld_wdata : cpu_wdata;
                        state     <= ACCESS;
                    end
                end
                ACCESS: begin
                    if (cntZero) begin
                        if (!mem_we) begin
                            rdata <= mem_rdata;
                        end
                        mem_en  <= 1'b0;
                        mem_we  <= 1'b0;
                        cpu_ack <= (grant == GRANT_CPU);
                        ld_ack  <= (grant == GRANT_LD);
                        state   <= RESP;
                    end
                end
                RESP: begin
                    lastGrant <= grant;
                    busy      <= 1'b0;
                    state     <= IDLE;
                end
                default: begin
                    busy   <= 1'b0;
                    mem_en <= 1'b0;
                    mem_we <= 1'b0;
                    state  <= IDLE;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_mem_arbiter.sv
// Bench for mem_arbiter: DUT0 LAT=2 round-robin, DUT1 LAT=2 fixed priority, DUT2 LAT=1 round-robin.
module tb_mem_arbiter;

    localparam int unsigned AW = 32;
    localparam int unsigned DW = 32;
    localparam int unsigned N  = 3;

    logic clk = 1'b0;
    logic rst_n;
    always #5 clk = ~clk;

    logic [N-1:0]  cpuReq, cpuWe, cpuAck, cpuStall, ldReq, ldWe, ldAck;
    logic [N-1:0]  memEn, memWe, busy, grant;
    logic [AW-1:0] cpuAddr [N];
    logic [AW-1:0] ldAddr [N];
    logic [AW-1:0] memAddr [N];
    logic [DW-1:0] cpuWdata [N];
    logic [DW-1:0] ldWdata [N];
    logic [DW-1:0] memWdata [N];
    logic [DW-1:0] memRdata [N];
    logic [DW-1:0] rdata [N];

    int checks = 0;
    int errors = 0;

    typedef struct {
        logic          cReq;
        logic          cWe;
        logic [AW-1:0] cAddr;
        logic          lReq;
        logic          lWe;
        logic [AW-1:0] lAddr;
        logic [DW-1:0] lWd;
        logic          eEn;
        logic          eWe;
        logic          eCAck;
        logic          eLAck;
        logic          eStall;
        logic          eBusy;
        logic          eGrant;
        logic [DW-1:0] eRdata;
        logic [AW-1:0] eAddr;
    } vec_t;

    vec_t vecs [12];

    for (genvar g = 0; g < N; g++) begin : gDut
        logic [DW-1:0] mem [64];

        mem_arbiter #(
            .ADDR_WIDTH     (AW),
            .DATA_WIDTH     (DW),
            .MEM_LATENCY    ((g == 2) ? 1 : 2),
            .FIXED_PRIORITY ((g == 1) ? 1 : 0)
        ) dut (
            .clk       (clk),
            .rst_n     (rst_n),
            .cpu_req   (cpuReq[g]),
            .cpu_we    (cpuWe[g]),
            .cpu_addr  (cpuAddr[g]),
            .cpu_wdata (cpuWdata[g]),
            .cpu_ack   (cpuAck[g]),
            .cpu_stall (cpuStall[g]),
            .ld_req    (ldReq[g]),
            .ld_we     (ldWe[g]),
            .ld_addr   (ldAddr[g]),
            .ld_wdata  (ldWdata[g]),
            .ld_ack    (ldAck[g]),
            .rdata     (rdata[g]),
            .mem_en    (memEn[g]),
            .mem_we    (memWe[g]),
            .mem_addr  (memAddr[g]),
            .mem_wdata (memWdata[g]),
            .mem_rdata (memRdata[g]),
            .busy      (busy[g]),
            .grant     (grant[g])
        );

        assign memRdata[g] = mem[memAddr[g][7:2]];

        always @(posedge clk) begin
            if (memEn[g] && memWe[g]) mem[memAddr[g][7:2]] <= memWdata[g];
        end

        initial begin
            for (int i = 0; i < 64; i++) mem[i] = '0;
            mem[16] = 32'hDEAD_BEEF;
        end
    end

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %h expected %h (t=%0t)", name, act, exp, $time);
        end
    endtask

    task automatic clearReqs();
        for (int d = 0; d < N; d++) begin
            cpuReq[d] = 1'b0; cpuWe[d] = 1'b0; cpuAddr[d] = '0; cpuWdata[d] = '0;
            ldReq[d]  = 1'b0; ldWe[d]  = 1'b0; ldAddr[d]  = '0; ldWdata[d]  = '0;
        end
    endtask

    task automatic setCpuRead(input int d, input logic [AW-1:0] addr);
        cpuReq[d] = 1'b1; cpuWe[d] = 1'b0; cpuAddr[d] = addr; cpuWdata[d] = '0;
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish, checks=%0d", checks);
        $fatal(1);
    end

    initial begin
        // cycle-by-cycle DUT0 vectors: core read 0x40, loader write 0x13 to 0x0, core read 0x0
        vecs[0]  = '{1, 0, 32'h40, 0, 0, 32'h0, 32'h0,  0, 0, 0, 0, 1, 0, 0, 32'h0, 32'h0};
        vecs[1]  = '{1, 0, 32'h40, 0, 0, 32'h0, 32'h0,  1, 0, 0, 0, 1, 1, 0, 32'h0, 32'h40};
        vecs[2]  = '{1, 0, 32'h40, 0, 0, 32'h0, 32'h0,  1, 0, 0, 0, 1, 1, 0, 32'h0, 32'h40};
        vecs[3]  = '{0, 0, 32'h0,  0, 0, 32'h0, 32'h0,  0, 0, 1, 0, 0, 1, 0, 32'hDEAD_BEEF, 32'h0};
        vecs[4]  = '{0, 0, 32'h0,  1, 1, 32'h0, 32'h13, 0, 0, 0, 0, 0, 0, 0, 32'hDEAD_BEEF, 32'h0};
        vecs[5]  = '{0, 0, 32'h0,  1, 1, 32'h0, 32'h13, 1, 1, 0, 0, 0, 1, 1, 32'hDEAD_BEEF, 32'h0};
        vecs[6]  = '{0, 0, 32'h0,  1, 1, 32'h0, 32'h13, 1, 1, 0, 0, 0, 1, 1, 32'hDEAD_BEEF, 32'h0};
        vecs[7]  = '{0, 0, 32'h0,  0, 0, 32'h0, 32'h0,  0, 0, 0, 1, 0, 1, 1, 32'hDEAD_BEEF, 32'h0};
        vecs[8]  = '{1, 0, 32'h0,  0, 0, 32'h0, 32'h0,  0, 0, 0, 0, 1, 0, 1, 32'hDEAD_BEEF, 32'h0};
        vecs[9]  = '{1, 0, 32'h0,  0, 0, 32'h0, 32'h0,  1, 0, 0, 0, 1, 1, 0, 32'hDEAD_BEEF, 32'h0};
        vecs[10] = '{1, 0, 32'h0,  0, 0, 32'h0, 32'h0,  1, 0, 0, 0, 1, 1, 0, 32'hDEAD_BEEF, 32'h0};
        vecs[11] = '{0, 0, 32'h0,  0, 0, 32'h0, 32'h0,  0, 0, 1, 0, 0, 1, 0, 32'h13, 32'h0};

        // reset values
        clearReqs();
        rst_n = 1'b0;
        repeat (2) @(posedge clk);
        #1;
        for (int d = 0; d < N; d++) begin
            check($sformatf("reset_ctrl%0d", d),
                  64'({memEn[d], memWe[d], cpuAck[d], ldAck[d], cpuStall[d], busy[d], grant[d], rdata[d]}),
                  64'(0));
            check($sformatf("reset_bus%0d", d), 64'({memAddr[d], memWdata[d]}), 64'(0));
        end
        rst_n = 1'b1;

        // idle with no requests
        for (int k = 0; k < 10; k++) begin
            @(negedge clk);
            check($sformatf("idle_c%0d", k), 64'({busy, memEn, cpuAck, ldAck}), 64'(0));
        end

        // table-driven single accesses on DUT0
        for (int i = 0; i < 12; i++) begin
            @(posedge clk);
            #1;
            cpuReq[0] = vecs[i].cReq; cpuWe[0] = vecs[i].cWe; cpuAddr[0] = vecs[i].cAddr;
            ldReq[0]  = vecs[i].lReq; ldWe[0]  = vecs[i].lWe; ldAddr[0]  = vecs[i].lAddr;
            ldWdata[0] = vecs[i].lWd;
            @(negedge clk);
            check($sformatf("vec%0d", i),
                  64'({memEn[0], memWe[0], cpuAck[0], ldAck[0], cpuStall[0], busy[0], grant[0], rdata[0]}),
                  64'({vecs[i].eEn, vecs[i].eWe, vecs[i].eCAck, vecs[i].eLAck, vecs[i].eStall,
                       vecs[i].eBusy, vecs[i].eGrant, vecs[i].eRdata}));
            if (vecs[i].eEn) check($sformatf("vec%0d_addr", i), 64'(memAddr[0]), 64'(vecs[i].eAddr));
        end

        // conflicts: both requesters held for 4 back-to-back accesses on DUT0 (RR) and DUT1 (fixed)
        @(posedge clk);
        #1;
        clearReqs();
        rst_n = 1'b0;
        #2;
        rst_n = 1'b1;
        for (int d = 0; d < 2; d++) begin
            setCpuRead(d, 32'h40);
            ldReq[d] = 1'b1; ldWe[d] = 1'b0; ldAddr[d] = 32'h0;
        end
        for (int k = 0; k < 16; k++) begin
            logic ldTurn;
            ldTurn = ((k / 4) % 2) == 1;
            @(negedge clk);
            if (k % 4 == 3) begin
                check($sformatf("conflict_ack_c%0d", k), 64'({cpuAck[0], ldAck[0], cpuAck[1], ldAck[1]}),
                      64'({~ldTurn, ldTurn, 1'b1, 1'b0}));
                check($sformatf("conflict_rdata_c%0d", k), 64'({rdata[0], rdata[1]}),
                      64'({ldTurn ? 32'h13 : 32'hDEAD_BEEF, 32'hDEAD_BEEF}));
            end else begin
                check($sformatf("conflict_noack_c%0d", k), 64'({cpuAck[1:0], ldAck[1:0]}), 64'(0));
            end
            if (k % 4 == 1) begin
                check($sformatf("conflict_grant_c%0d", k), 64'({grant[0], grant[1]}), 64'({ldTurn, 1'b0}));
            end
            @(posedge clk);
            #1;
        end
        clearReqs();

        // reset in the middle of an access, request held across it
        setCpuRead(0, 32'h40);
        @(posedge clk);
        #1;
        @(negedge clk);
        check("rstmid_access", 64'({memEn[0], busy[0]}), 64'({1'b1, 1'b1}));
        #1;
        rst_n = 1'b0;
        #1;
        check("rstmid_drop", 64'({memEn[0], busy[0], cpuAck[0], ldAck[0]}), 64'(0));
        @(posedge clk);
        #1;
        check("rstmid_noack", 64'({memEn[0], cpuAck[0], ldAck[0]}), 64'(0));
        rst_n = 1'b1;
        for (int k = 0; k < 6; k++) begin
            @(negedge clk);
            check($sformatf("rstmid_resume_c%0d", k), 64'({cpuAck[0], ldAck[0], memEn[0]}),
                  64'({k == 3, 1'b0, (k == 1) || (k == 2)}));
            if (k == 3) begin
                check("rstmid_rdata", 64'(rdata[0]), 64'(32'hDEAD_BEEF));
                cpuReq[0] = 1'b0;
            end
            @(posedge clk);
            #1;
        end

        // request dropped mid-access on DUT0 (LAT=2); plain read on DUT2 (LAT=1)
        setCpuRead(0, 32'h40);
        setCpuRead(2, 32'h40);
        for (int k = 0; k < 5; k++) begin
            if (k == 2) cpuReq[0] = 1'b0;
            @(negedge clk);
            check($sformatf("drop_c%0d", k),
                  64'({cpuAck[0], cpuStall[0], ldAck[0], busy[0], memEn[2], cpuAck[2], cpuStall[2]}),
                  64'({k == 3, k < 2, 1'b0, (k >= 1) && (k <= 3), k == 1, k == 2, k < 2}));
            if (k == 2) begin
                check("lat1_rdata", 64'(rdata[2]), 64'(32'hDEAD_BEEF));
                cpuReq[2] = 1'b0;
            end
            if (k == 3) check("drop_rdata", 64'(rdata[0]), 64'(32'hDEAD_BEEF));
            @(posedge clk);
            #1;
        end

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
